// File: rtl/gray_counter_pkg.sv
// Shared constants and Gray-code helpers for the gray_counter block and its consumers.
// Helpers work on GRAY_MAX_W-bit vectors; callers zero-extend and truncate.
`timescale 1ns/1ps
package gray_counter_pkg;

  localparam int GRAY_WIDTH = 17;
  localparam int GRAY_MAX_W = 64;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it. Doubling shifts build that prefix XOR.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = g;
    for (int s = 1; s < GRAY_MAX_W; s = s * 2) b = b ^ (b >> s);
    return b;
  endfunction

endpackage

// File: rtl/gray_counter.sv
// Free-running WIDTH-bit Gray counter with enable and async active-low reset.
// The output is a register, so downstream logic can use its bits as divided clocks.
`timescale 1ns/1ps
module gray_counter
  import gray_counter_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] gray_count
);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_next_gray;

  assign w_next_bin  = r_bin + WIDTH'(1);
  // Encode the next binary value so the Gray register changes on the same edge as the count.
  assign w_next_gray = WIDTH'(bin2gray(GRAY_MAX_W'(w_next_bin)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bin  <= '0;
      r_gray <= '0;
    end else if (enable) begin
      r_bin  <= w_next_bin;
      r_gray <= w_next_gray;
    end
  end

  assign gray_count = r_gray;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: vector table, hand sequences, random enable/reset vs a count model.
`timescale 1ns/1ps
module tb_gray_counter;
  import gray_counter_pkg::*;

  logic        clk;
  logic        rst17, en17;
  logic [16:0] g17;
  logic        rst4, en4;
  logic [3:0]  g4;
  logic        rst10, en10;
  logic [9:0]  g10;

  int n_chk  = 0;
  int n_pass = 0;
  int off_edge = 0;

  gray_counter u17 (.clk(clk), .reset(rst17), .enable(en17), .gray_count(g17));
  gray_counter #(.WIDTH(4))  u4  (.clk(clk), .reset(rst4),  .enable(en4),  .gray_count(g4));
  gray_counter #(.WIDTH(10)) u10 (.clk(clk), .reset(rst10), .enable(en10), .gray_count(g10));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges fall at 5 mod 10; any out-of-reset output change elsewhere is a glitch.
  always @(g17) if (rst17 === 1'b1 && ($time % 10) != 5) off_edge++;

  typedef struct {
    logic        rst;
    logic        en;
    logic [16:0] exp;
  } vec_t;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    vec_t              vt[$];
    int                seq4[18];
    logic [16:0]       samp[0:1100];
    longint unsigned   cnt;
    logic [16:0]       prev;
    logic [9:0]        prev10;
    int                last_t, ntog;
    int                bits[3];

    rst17 = 1'b0; en17 = 1'b1;
    rst4  = 1'b0; en4  = 1'b0;
    rst10 = 1'b0; en10 = 1'b0;
    tick();
    chk("reset_state", g17, 0);

    // Reset held 3 edges, 5 counting edges, 10 held edges, then resume.
    for (int i = 0; i < 3; i++) vt.push_back('{1'b0, 1'b1, 17'h0});
    vt.push_back('{1'b1, 1'b1, 17'h1});
    vt.push_back('{1'b1, 1'b1, 17'h3});
    vt.push_back('{1'b1, 1'b1, 17'h2});
    vt.push_back('{1'b1, 1'b1, 17'h6});
    vt.push_back('{1'b1, 1'b1, 17'h7});
    for (int i = 0; i < 10; i++) vt.push_back('{1'b1, 1'b0, 17'h7});
    vt.push_back('{1'b1, 1'b1, 17'h5});
    vt.push_back('{1'b1, 1'b1, 17'h4});
    vt.push_back('{1'b1, 1'b1, 17'hC});
    foreach (vt[i]) begin
      rst17 = vt[i].rst;
      en17  = vt[i].en;
      tick();
      chk($sformatf("vec%0d", i), g17, vt[i].exp);
    end

    // Async reset in the middle of the clock-low phase.
    rst17 = 1'b0; tick();
    rst17 = 1'b1; en17 = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("async_pre", g17, 17'h6);
    @(negedge clk); #2;
    rst17 = 1'b0;
    #1;
    chk("async_clear", g17, 0);
    tick();
    rst17 = 1'b1;
    tick(); chk("async_resume1", g17, 17'h1);
    tick(); chk("async_resume3", g17, 17'h3);

    // Divided-clock periods: toggle spacing must be half the period, every time.
    rst17 = 1'b0; tick();
    rst17 = 1'b1; en17 = 1'b1;
    samp[0] = g17;
    for (int k = 1; k <= 1100; k++) begin
      tick();
      samp[k] = g17;
    end
    bits = '{0, 1, 7};
    foreach (bits[j]) begin
      last_t = -1; ntog = 0;
      for (int k = 1; k <= 1100; k++) begin
        if (samp[k][bits[j]] != samp[k-1][bits[j]]) begin
          if (last_t >= 0) chk($sformatf("halfper_bit%0d_t%0d", bits[j], k), k - last_t, 2 << bits[j]);
          last_t = k; ntog++;
        end
      end
      chk($sformatf("toggles_bit%0d_enough", bits[j]), ntog >= 3, 1);
    end
    chk("no_offedge_toggle", off_edge, 0);

    // Random enable/reset against an integer count model.
    rst17 = 1'b0; tick();
    cnt = 0;
    for (int k = 0; k < 3000; k++) begin
      prev  = g17;
      rst17 = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      en17  = ($urandom_range(0, 3) != 0);
      tick();
      if (!rst17) cnt = 0;
      else if (en17) cnt = (cnt + 1) % (64'd1 << 17);
      chk($sformatf("rnd%0d", k), g17, cnt ^ (cnt >> 1));
      if (rst17 && en17) chk($sformatf("rnd_onebit%0d", k), $countones(prev ^ g17), 1);
    end
    chk("no_x", $isunknown(g17), 0);
    chk("no_offedge_toggle_rnd", off_edge, 0);

    // WIDTH=4 full sequence including wrap.
    seq4 = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0, 1, 3};
    rst4 = 1'b0; tick();
    rst4 = 1'b1; en4 = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tick();
      chk($sformatf("w4_step%0d", k + 1), g4, seq4[k]);
    end

    // WIDTH=10 full cycle plus two: wrap at binary all-ones, top-bit half period 512.
    rst10 = 1'b0; tick();
    rst10 = 1'b1; en10 = 1'b1;
    last_t = -1;
    for (int k = 1; k <= 1026; k++) begin
      prev10 = g10;
      tick();
      chk($sformatf("w10_onebit%0d", k), $countones(prev10 ^ g10), 1);
      chk($sformatf("w10_bin%0d", k), gray2bin(64'(g10)), k % 1024);
      if (g10[9] != prev10[9]) begin
        if (last_t >= 0) chk("w10_msb_halfper", k - last_t, 512);
        last_t = k;
      end
      if (k == 1023) chk("w10_allones", g10, 10'h200);
      if (k == 1024) chk("w10_wrap0", g10, 0);
      if (k == 1025) chk("w10_wrap1", g10, 1);
    end
    chk("w10_msb_seen", last_t, 1024);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
